// File: rtl/cache_stats_collector.sv
// Per-access hit/miss statistics for the L1I/L1D/L2 cache model, with a
// snapshot-and-stream readout that never stalls the live counters.

module cache_stats_cnt #(
  parameter int CNT_W = 32,
  parameter int SAT   = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             i_clr,
  input  logic             i_inc,
  output logic [CNT_W-1:0] o_cnt
);
  logic [CNT_W-1:0] r_cnt;
  logic             w_hold;

  // Saturating mode freezes an all-ones counter; wrapping mode lets it roll.
  assign w_hold = (SAT != 0) && (&r_cnt);

  always_ff @(posedge clk) begin
    if (!rst)                 r_cnt <= '0;
    else if (i_clr)           r_cnt <= '0;
    else if (i_inc && !w_hold) r_cnt <= r_cnt + {{(CNT_W-1){1'b0}}, 1'b1};
  end

  assign o_cnt = r_cnt;
endmodule

module cache_stats_collector #(
  parameter int CNT_W = 32,
  parameter int SAT   = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             acc_valid,
  input  logic             acc_instr,
  input  logic             L1h,
  input  logic             L2h,
  input  logic             clr,
  input  logic             dump_req,
  output logic             dump_busy,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [2:0]       out_id,
  output logic [CNT_W-1:0] out_data,
  output logic             out_last
);
  localparam int         NCNT   = 7;
  localparam logic [2:0] LAST_ID = 3'd6;
  localparam logic [0:0] S_IDLE = 1'b0;
  localparam logic [0:0] S_SEND = 1'b1;

  logic [NCNT-1:0]            w_inc;
  logic [NCNT-1:0][CNT_W-1:0] w_cnt;
  logic [NCNT-1:0][CNT_W-1:0] r_snap;
  logic [0:0]                 r_state;
  logic [2:0]                 r_id;
  logic                       w_l1_miss;

  // L2 counters only see accesses that missed in L1.
  assign w_l1_miss = acc_valid & ~L1h;
  assign w_inc[0]  = acc_valid;
  assign w_inc[1]  = acc_valid &  acc_instr &  L1h;
  assign w_inc[2]  = acc_valid &  acc_instr & ~L1h;
  assign w_inc[3]  = acc_valid & ~acc_instr &  L1h;
  assign w_inc[4]  = acc_valid & ~acc_instr & ~L1h;
  assign w_inc[5]  = w_l1_miss &  L2h;
  assign w_inc[6]  = w_l1_miss & ~L2h;

  for (genvar g = 0; g < NCNT; g++) begin : g_cnt
    cache_stats_cnt #(.CNT_W(CNT_W), .SAT(SAT)) u_cnt (
      .clk   (clk),
      .rst   (rst),
      .i_clr (clr),
      .i_inc (w_inc[g]),
      .o_cnt (w_cnt[g])
    );
  end

  // Snapshot takes the pre-edge live values, so a same-cycle access is live only.
  always_ff @(posedge clk) begin
    if (!rst) begin
      r_state <= S_IDLE;
      r_id    <= '0;
      r_snap  <= '0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (dump_req) begin
            r_snap  <= w_cnt;
            r_id    <= '0;
            r_state <= S_SEND;
          end
        end
        S_SEND: begin
          if (out_ready) begin
            if (r_id == LAST_ID) begin
              r_state <= S_IDLE;
              r_id    <= '0;
            end else begin
              r_id <= r_id + 3'd1;
            end
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign out_valid = (r_state == S_SEND);
  assign dump_busy = out_valid;
  assign out_id    = r_id;
  assign out_last  = out_valid && (r_id == LAST_ID);
  assign out_data  = out_valid ? r_snap[r_id] : '0;
endmodule

// File: tb/tb_cache_stats_collector.sv
// Bench for cache_stats_collector: three instances (32-bit saturating, 4-bit
// saturating, 4-bit wrapping) share one stimulus stream against a count model.

module tb_cache_stats_collector;
  logic clk = 1'b0;
  logic rst = 1'b0, acc_valid = 1'b0, acc_instr = 1'b0, L1h = 1'b0, L2h = 1'b0;
  logic clr = 1'b0, dump_req = 1'b0, out_ready = 1'b0;

  logic busy_a, valid_a, last_a; logic [2:0] id_a; logic [31:0] data_a;
  logic busy_s, valid_s, last_s; logic [2:0] id_s; logic [3:0]  data_s;
  logic busy_w, valid_w, last_w; logic [2:0] id_w; logic [3:0]  data_w;

  always #5 clk = ~clk;

  cache_stats_collector #(.CNT_W(32), .SAT(1)) u_dut_a (
    .clk(clk), .rst(rst), .acc_valid(acc_valid), .acc_instr(acc_instr), .L1h(L1h), .L2h(L2h),
    .clr(clr), .dump_req(dump_req), .dump_busy(busy_a), .out_valid(valid_a), .out_ready(out_ready),
    .out_id(id_a), .out_data(data_a), .out_last(last_a));
  cache_stats_collector #(.CNT_W(4), .SAT(1)) u_dut_s (
    .clk(clk), .rst(rst), .acc_valid(acc_valid), .acc_instr(acc_instr), .L1h(L1h), .L2h(L2h),
    .clr(clr), .dump_req(dump_req), .dump_busy(busy_s), .out_valid(valid_s), .out_ready(out_ready),
    .out_id(id_s), .out_data(data_s), .out_last(last_s));
  cache_stats_collector #(.CNT_W(4), .SAT(0)) u_dut_w (
    .clk(clk), .rst(rst), .acc_valid(acc_valid), .acc_instr(acc_instr), .L1h(L1h), .L2h(L2h),
    .clr(clr), .dump_req(dump_req), .dump_busy(busy_w), .out_valid(valid_w), .out_ready(out_ready),
    .out_id(id_w), .out_data(data_w), .out_last(last_w));

  int     n_chk = 0, n_err = 0, n_words = 0;
  bit     chk_en = 1'b0;
  longint m_cnt[7], m_snap[7];   // unbounded event counts since last clear
  int     m_q[$];                // counter ids still to be streamed
  longint got_a[7], got_s[7], got_w[7], exp7[7];

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d, expected %0d", tag, obs, exp);
    end
  endtask

  function automatic longint fold(longint x, int w, bit sat);
    longint mx = (longint'(1) << w) - 1;
    return sat ? ((x > mx) ? mx : x) : (x & mx);
  endfunction

  task automatic check_outs();
    bit b = (m_q.size() != 0);
    int id = b ? m_q[0] : 0;
    chk("valid", valid_a, b);   chk("busy", busy_a, b);
    chk("valid_s", valid_s, b); chk("busy_s", busy_s, b);
    chk("valid_w", valid_w, b); chk("busy_w", busy_w, b);
    chk("last", last_a, b && id == 6);
    chk("last_s", last_s, b && id == 6);
    chk("last_w", last_w, b && id == 6);
    if (b) begin
      chk("id", id_a, id);
      chk("data", data_a, fold(m_snap[id], 32, 1'b1));
      chk("data_s", data_s, fold(m_snap[id], 4, 1'b1));
      chk("data_w", data_w, fold(m_snap[id], 4, 1'b0));
    end
  endtask

  // One clock: check current outputs, record accepted words, then advance the model.
  task automatic tick();
    bit busy0 = (m_q.size() != 0);
    if (chk_en) check_outs();
    if (valid_a && out_ready) begin
      got_a[id_a] = data_a; got_s[id_s] = data_s; got_w[id_w] = data_w;
      n_words++;
    end
    @(posedge clk);
    if (!rst) begin
      foreach (m_cnt[i]) begin m_cnt[i] = 0; m_snap[i] = 0; end
      m_q.delete();
    end else begin
      if (busy0 && out_ready) void'(m_q.pop_front());
      else if (!busy0 && dump_req) begin
        m_snap = m_cnt;
        m_q = '{0, 1, 2, 3, 4, 5, 6};
      end
      if (clr) foreach (m_cnt[i]) m_cnt[i] = 0;
      else if (acc_valid) begin
        m_cnt[0]++;
        m_cnt[acc_instr ? (L1h ? 1 : 2) : (L1h ? 3 : 4)]++;
        if (!L1h) m_cnt[L2h ? 5 : 6]++;
      end
    end
    #1;
  endtask

  task automatic set_in(input bit v, input bit ins, input bit l1, input bit l2);
    acc_valid = v; acc_instr = ins; L1h = l1; L2h = l2;
  endtask

  task automatic acc(input bit ins, input bit l1, input bit l2);
    set_in(1'b1, ins, l1, l2); tick(); set_in(1'b0, 1'b0, 1'b0, 1'b0);
  endtask

  task automatic clr_got();
    foreach (got_a[i]) begin got_a[i] = -1; got_s[i] = -1; got_w[i] = -1; end
    n_words = 0;
  endtask

  task automatic drain(input string tag);
    for (int k = 0; k < 40 && valid_a; k++) tick();
    chk({tag, "_done"}, valid_a, 1'b0);
  endtask

  task automatic dump(input string tag);
    clr_got(); out_ready = 1'b1; dump_req = 1'b1; tick(); dump_req = 1'b0;
    drain(tag);
    chk({tag, "_words"}, n_words, 7);
  endtask

  task automatic chk_got(input string tag);
    for (int i = 0; i < 7; i++) chk($sformatf("%s_w%0d", tag, i), got_a[i], exp7[i]);
  endtask

  task automatic sc2_stim();
    repeat (3) acc(1'b1, 1'b1, 1'b0);
    repeat (2) acc(1'b0, 1'b0, 1'b1);
    acc(1'b1, 1'b0, 1'b0);
  endtask

  initial begin
    foreach (m_cnt[i]) begin m_cnt[i] = 0; m_snap[i] = 0; end
    clr_got();
    // reset and an all-zero dump
    rst = 1'b0; tick(); chk_en = 1'b1; tick(); rst = 1'b1;
    chk("rst_valid", valid_a, 1'b0); chk("rst_busy", busy_a, 1'b0);
    chk("rst_id", id_a, 3'd0); chk("rst_data", data_a, 32'd0); chk("rst_last", last_a, 1'b0);
    dump("s1");
    exp7 = '{0, 0, 0, 0, 0, 0, 0}; chk_got("s1");
    chk("s1_busy_after", busy_a, 1'b0);

    // directed mix
    sc2_stim(); dump("s2");
    exp7 = '{6, 3, 1, 0, 2, 2, 1}; chk_got("s2");

    // back-pressure at id 2 while accesses keep arriving
    clr = 1'b1; tick(); clr = 1'b0;
    sc2_stim();
    clr_got(); out_ready = 1'b1; dump_req = 1'b1; tick(); dump_req = 1'b0;
    tick(); tick();
    out_ready = 1'b0;
    for (int k = 0; k < 5; k++) begin
      if (k < 4) set_in(1'b1, 1'b1, 1'b1, 1'b0); else set_in(1'b0, 1'b0, 1'b0, 1'b0);
      chk("s3_hold_id", id_a, 3'd2); chk("s3_hold_data", data_a, 32'd1);
      chk("s3_hold_valid", valid_a, 1'b1);
      tick();
    end
    set_in(1'b0, 1'b0, 1'b0, 1'b0); out_ready = 1'b1;
    drain("s3");
    chk_got("s3");
    dump("s3b"); chk("s3_total", got_a[0], 10);

    // narrow counters: saturate vs wrap
    clr = 1'b1; tick(); clr = 1'b0;
    repeat (20) acc(1'b1, 1'b1, 1'b0);
    dump("s4");
    chk("s4_a0", got_a[0], 20); chk("s4_a1", got_a[1], 20);
    chk("s4_sat0", got_s[0], 15); chk("s4_sat1", got_s[1], 15);
    chk("s4_wrap0", got_w[0], 4); chk("s4_wrap1", got_w[1], 4);

    // clear beats a same-cycle access; dump_req mid-dump is dropped
    acc(1'b0, 1'b1, 1'b0); acc(1'b1, 1'b0, 1'b1); acc(1'b0, 1'b0, 1'b0);
    set_in(1'b1, 1'b1, 1'b1, 1'b0); clr = 1'b1; tick(); clr = 1'b0; set_in(1'b0, 1'b0, 1'b0, 1'b0);
    dump("s5");
    exp7 = '{0, 0, 0, 0, 0, 0, 0}; chk_got("s5");
    clr_got(); out_ready = 1'b1; dump_req = 1'b1; tick(); dump_req = 1'b0;
    for (int k = 0; k < 40 && valid_a; k++) begin
      dump_req = (id_a == 3'd3); tick(); dump_req = 1'b0;
    end
    chk("s5_words", n_words, 7);
    tick(); tick();
    chk("s5_idle", valid_a, 1'b0);

    // reset in the middle of a dump
    acc(1'b1, 1'b0, 1'b1); acc(1'b0, 1'b1, 1'b0);
    out_ready = 1'b1; dump_req = 1'b1; tick(); dump_req = 1'b0;
    tick(); tick(); tick();
    chk("s6_id", id_a, 3'd3);
    rst = 1'b0; tick(); rst = 1'b1;
    chk("s6_valid", valid_a, 1'b0); chk("s6_busy", busy_a, 1'b0);
    dump("s6");
    exp7 = '{0, 0, 0, 0, 0, 0, 0}; chk_got("s6");

    // random traffic
    for (int n = 0; n < 3000; n++) begin
      rst       = ($urandom_range(0, 499) != 0);
      set_in($urandom_range(0, 9) < 7, 1'($urandom), 1'($urandom), 1'($urandom));
      clr       = ($urandom_range(0, 63) == 0);
      dump_req  = ($urandom_range(0, 15) == 0);
      out_ready = ($urandom_range(0, 3) != 0);
      tick();
    end
    rst = 1'b1; clr = 1'b0; dump_req = 1'b0; set_in(1'b0, 1'b0, 1'b0, 1'b0); out_ready = 1'b1;
    drain("rnd");
    dump("fin");
    for (int i = 0; i < 7; i++) chk($sformatf("fin_w%0d", i), got_a[i], m_cnt[i]);

    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end
endmodule

// File: doc/cache_stats_collector.md
Name: cache_stats_collector

Overview:
- Sits directly downstream of the direct-mapped L1/L2 cache model and consumes its per-access hit/miss result (L1h, L2h).
- Accumulates access, hit and miss counts separately for L1 instruction, L1 data and L2.
- On request, snapshots all counters and streams them out one word at a time over a valid/ready handshake, so the trace bench can read results without stopping the access stream.

Parameters:
- CNT_W, 32, width of each counter and of out_data.
- SAT, 1, 1 = counters saturate at all-ones; 0 = counters wrap modulo 2^CNT_W.

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  synchronous, active-low reset.
- acc_valid  in  1  one cache access result is presented this cycle.
- acc_instr  in  1  1 = instruction access (L1I), 0 = data access (L1D).
- L1h  in  1  L1 hit (1) or miss (0).
- L2h  in  1  L2 hit; used only when L1h=0.
- clr  in  1  synchronous clear of all live counters.
- dump_req  in  1  request snapshot and readout.
- dump_busy  out  1  readout in progress.
- out_valid  out  1  out_id/out_data valid.
- out_ready  in  1  consumer accepts the current word.
- out_id  out  3  counter index of the current word.
- out_data  out  CNT_W  counter value from the snapshot.
- out_last  out  1  current word is index 6.

Behaviour:
- Reset is sampled only on a rising clk edge with rst=0. Its effect at that edge:
  - all 7 live counters are cleared;
  - all snapshot registers are cleared;
  - the FSM returns to IDLE;
  - dump_busy, out_valid, out_id and out_last go to 0;
  - out_data goes to 0.
- Counter indices:
  - 0 total accesses
  - 1 L1I hit
  - 2 L1I miss
  - 3 L1D hit
  - 4 L1D miss
  - 5 L2 hit
  - 6 L2 miss
- Update on an edge with acc_valid=1:
  - total +1.
  - acc_instr=1: L1h=1 → idx1 +1; L1h=0 → idx2 +1.
  - acc_instr=0: L1h=1 → idx3 +1; L1h=0 → idx4 +1.
  - L1h=0 and L2h=1 → idx5 +1.
  - L1h=0 and L2h=0 → idx6 +1.
  - L1h=1 → L2h is ignored and no L2 counter changes.
- Latency: the updated value is visible in the live counter one cycle after the edge.
- Arithmetic: each counter is an independent CNT_W adder.
  - SAT=1: a counter at 2^CNT_W−1 holds its value.
  - SAT=0: it wraps to 0.
- clr=1 zeroes all live counters at the edge.
  - clr and acc_valid in the same cycle: clr wins and the access is not counted.
  - clr does not affect the snapshot or an in-progress dump.
- FSM states: IDLE, SEND.
  - IDLE, dump_req=1: copy the live counter values as registered before this edge's update into the snapshot. Set out_id=0, out_valid=1, dump_busy=1, and go to SEND. An access in the same cycle is counted live but is not in the snapshot.
  - SEND: out_data = snapshot[out_id]; out_last = (out_id==6).
  - SEND, out_valid & out_ready & out_id<6: out_id +1 next cycle.
  - SEND, out_valid & out_ready & out_id==6: go to IDLE; out_valid, dump_busy, out_last = 0 next cycle.
  - SEND, out_ready=0: out_id and out_data hold stable; out_valid stays 1 (no retraction).
  - dump_req while in SEND is ignored (not queued).
  - dump_req in the same cycle the last word is accepted is ignored. A new dump is possible from the following cycle.
- Counting continues in every state. A dump never stalls or drops accesses.
- Reset mid-dump: the FSM returns to IDLE with out_valid=0 at that edge, and counters and snapshot are zeroed.
- Minimum dump length: 7 cycles with out_ready held high.

Test Plan:
1. Apply rst=0 for 2 cycles, then dump_req with out_ready=1 → 7 words, ids 0..6, all data 0, out_last only on id 6, dump_busy low on the following cycle.
2. Send 3 instruction accesses with L1h=1, then 2 data accesses with L1h=0/L2h=1, then 1 instruction access with L1h=0/L2h=0, then dump → values [6,3,1,0,2,2,1].
3. Fill the counters using the scenario 2 stimulus, then dump with out_ready=0 for 5 cycles at id 2 and 4 accesses issued during the dump → id 2 and data 1 are held stable the whole time, and dumped values still read [6,3,1,0,2,2,1]. A second dump reads total=10.
4. With CNT_W=4, SAT=1: 20 instruction hits → idx0=15, idx1=15. With SAT=0, same stimulus → idx0=4, idx1=4.
5. Assert clr together with acc_valid after several accesses → next dump is all 0. A dump_req pulsed at id 3 of an active dump → exactly 7 words, no second dump starts.
6. Assert rst=0 while out_id=3 in SEND → out_valid=0 and dump_busy=0 after the edge, and a subsequent dump returns all 0.
